prbs_checker: RTL
=================

// Module: prbs_checker
// PURPOSE
//  Receive end of the digital-signal link: samples the serial pseudo-random (m-sequence) stream and its bit clock.
//  Self-synchronises a local m-sequence predictor to the stream, then counts received bits and bit errors.
//  Sits after the signal generator / channel; counters feed the display and control logic.
// PARAMETERS
//  PRBS_ORDER   8       LFSR length N (history register width)
//  TAP_MASK     8'hB8   feedback taps over history h (h[0] = newest bit); 8'hB8 = x^8+x^6+x^5+x^4+1
//  SYNC_RUN     32      consecutive correct predictions required to declare lock
//  WIN_LEN      256     bits per error-monitoring window while locked
//  LOSS_THRESH  16      errors within one window that force loss of lock
//  CNT_W        24      width of bit_cnt / err_cnt
//  TIMEOUT_CYC  4096    clk cycles without a sig_clk edge before clock loss (macro only)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  sig_data   in   1      serial data, asynchronous to clk; sender changes it on sig_clk falling edge
//  sig_clk    in   1      bit clock, asynchronous to clk, much slower than clk (>= 8 clk per half period)
//  clr_cnt    in   1      synchronous clear of bit_cnt / err_cnt
//  locked     out  1      1 while in state LOCK
//  bit_err    out  1      one-cycle pulse per mismatched bit while locked
//  bit_cnt    out  CNT_W  bits checked while locked, saturating
//  err_cnt    out  CNT_W  errors counted while locked, saturating
//  clk_lost   out  1      sig_clk timeout flag (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=SEARCH; history h, fill/run/window counters, all outputs = 0.
//  Input path: sig_clk and sig_data each pass through identical 2-FF synchronisers.
//   A rising edge of the synchronised sig_clk yields a 1-cycle strobe; sample d = synchronised sig_data in that cycle.
//  Latency: strobe at cycle t -> locked/bit_err/counters are registered and valid at t+1.
//   sig_clk pin edge to strobe is 2-3 clk.
//  Prediction: p = ^(h & TAP_MASK). Error e = (d != p), evaluated only when fill == N.
//  SEARCH:
//   - Per strobe: h <= {h[N-2:0], d}; fill increments, saturating at N.
//   - Once fill == N: e=0 and h != 0 -> run++; otherwise run <= 0.
//   - If run reaches SYNC_RUN on this strobe -> go to LOCK; window and window-error counters cleared.
//   - All-zero history never advances run (prevents false lock on a stuck-low line).
//  LOCK:
//   - Predictor free-runs: h <= {h[N-2:0], p}; received bits never enter h (one channel error = one count).
//   - Per strobe: bit_cnt++ and win++; if e then err_cnt++, win_err++, bit_err pulses.
//   - If win_err reaches LOSS_THRESH -> SEARCH; fill and run cleared; counters hold their values.
//   - At win == WIN_LEN: win and win_err cleared.
//   - Loss of lock and window end on the same strobe: loss wins.
//  Counters: saturate at all-ones, no wrap.
//   - clr_cnt has priority over an increment in the same cycle (result is 0).
//   - clr_cnt does not affect state, h or window counters.
//  Reset mid-stream: immediate return to SEARCH; re-lock needs N + SYNC_RUN clean bits.
// CONFIGURATION
//  Macro PRBS_CHK_TIMEOUT_EN:
//   - Defined: a counter tracks clk cycles since the last strobe.
//     Reaching TIMEOUT_CYC sets clk_lost=1, forces SEARCH and clears fill/run.
//     The next strobe clears clk_lost.
//   - Undefined: no counter; clk_lost is constant 0; TIMEOUT_CYC is unused.
// STRUCTURE
//  Shared include prbs_defs.vh:
//   - State encodings SEARCH=1'b0, LOCK=1'b1.
//   - Default PRBS_ORDER / TAP_MASK pair, shared with the generator so both ends agree.
//  Sub-module sig_edge_sync: 2-FF synchroniser for data and clock plus rising-edge strobe.
//   Reused for the button inputs elsewhere.
//  Top holds the predictor, FSM, window logic and counters.
// TESTING
//  1. Clean PRBS-8 (TAP 8'hB8) from a model generator, 100 bits
//     -> locked rises after exactly N+SYNC_RUN=40 strobes; err_cnt=0; bit_cnt = bits after lock.
//  2. Locked; flip 1 bit every 50
//     -> bit_err pulses once per flip, 1 cycle after its strobe; err_cnt matches flips; lock held.
//  3. Locked; invert 16 consecutive bits
//     -> err_cnt +16; locked falls at t+1 of the 16th error; re-locks 40 strobes after clean data resumes.
//  4. sig_data stuck 0 for 500 bits from reset -> never locks; counters stay 0.
//  5. clr_cnt asserted on a strobe cycle carrying an error -> bit_cnt=err_cnt=0 next cycle.
//     Preset err_cnt near max and inject errors -> holds at 2^CNT_W-1.
//  6. With PRBS_CHK_TIMEOUT_EN: stop sig_clk while locked
//     -> clk_lost=1 and locked=0 after TIMEOUT_CYC cycles; restart -> clk_lost clears on first strobe.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS link: FSM encoding and the default generator polynomial,
// so the generator and checker ends agree on the sequence.
package prbs_checker_pkg;

    typedef enum logic {
        StSearch = 1'b0,
        StLock   = 1'b1
    } state_e;

    localparam int unsigned DefPrbsOrder = 8;
    localparam logic [7:0]  DefTapMask   = 8'hB8;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchroniser for an asynchronous data/clock pair, with a one-cycle strobe on each
// rising edge of the synchronised clock.
module sig_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_data,
    input  logic sig_clk,
    output logic data_sync,
    output logic strobe
);

    logic [1:0] data_q;
    logic [1:0] sclk_q;
    logic       sclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            sclk_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            data_q      <= {data_q[0], sig_data};
            sclk_q      <= {sclk_q[0], sig_clk};
            sclk_prev_q <= sclk_q[1];
        end
    end

    assign data_sync = data_q[1];
    assign strobe    = sclk_q[1] & ~sclk_prev_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: locks a local m-sequence predictor onto sig_data, then counts bits and errors.
// Defining PRBS_CHK_TIMEOUT_EN adds sig_clk loss detection (clk_lost); otherwise clk_lost is 0.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int unsigned           PRBS_ORDER  = DefPrbsOrder,
    parameter logic [PRBS_ORDER-1:0] TAP_MASK    = PRBS_ORDER'(DefTapMask),
    parameter int unsigned           SYNC_RUN    = 32,
    parameter int unsigned           WIN_LEN     = 256,
    parameter int unsigned           LOSS_THRESH = 16,
    parameter int unsigned           CNT_W       = 24,
    parameter int unsigned           TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_data,
    input  logic             sig_clk,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             clk_lost
);

    localparam int unsigned FillW = cnt_width(PRBS_ORDER);
    localparam int unsigned RunW  = cnt_width(SYNC_RUN);
    localparam int unsigned WinW  = cnt_width(WIN_LEN);
    localparam int unsigned WerrW = cnt_width(LOSS_THRESH);

    localparam logic [FillW-1:0] FillFull = FillW'(PRBS_ORDER);
    localparam logic [RunW-1:0]  RunLast  = RunW'(SYNC_RUN - 1);
    localparam logic [WinW-1:0]  WinLast  = WinW'(WIN_LEN - 1);
    localparam logic [WerrW-1:0] WerrLast = WerrW'(LOSS_THRESH - 1);

    state_e                state_q, state_d;
    logic [PRBS_ORDER-1:0] h_q, h_d;
    logic [FillW-1:0]      fill_q, fill_d;
    logic [RunW-1:0]       run_q, run_d;
    logic [WinW-1:0]       win_q, win_d;
    logic [WerrW-1:0]      win_err_q, win_err_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic                  bit_err_q, bit_err_d;

    logic d, strobe;
    logic pred, full, mismatch, good;
    logic lock_hit, loss_hit, win_end, timeout_hit;

    sig_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_data  (sig_data),
        .sig_clk   (sig_clk),
        .data_sync (d),
        .strobe    (strobe)
    );

    assign pred     = ^(h_q & TAP_MASK);
    assign full     = (fill_q == FillFull);
    assign mismatch = full && (d != pred);
    // An all-zero history predicts zeros forever, so it must never count towards lock.
    assign good     = full && !mismatch && (h_q != '0);
    assign lock_hit = strobe && (state_q == StSearch) && good && (run_q == RunLast);
    assign loss_hit = strobe && (state_q == StLock) && mismatch && (win_err_q == WerrLast);
    assign win_end  = strobe && (state_q == StLock) && (win_q == WinLast);

`ifdef PRBS_CHK_TIMEOUT_EN
    localparam int unsigned    ToW    = cnt_width(TIMEOUT_CYC);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           clk_lost_q, clk_lost_d;

    always_comb begin
        to_cnt_d   = to_cnt_q;
        clk_lost_d = clk_lost_q;
        if (strobe) begin
            to_cnt_d   = '0;
            clk_lost_d = 1'b0;
        end else if (!clk_lost_q) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == ToLast) begin
                clk_lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q   <= '0;
            clk_lost_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            clk_lost_q <= clk_lost_d;
        end
    end

    assign timeout_hit = !strobe && !clk_lost_q && (to_cnt_q == ToLast);
    assign clk_lost    = clk_lost_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign clk_lost           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_hit || loss_hit) begin
            state_d = StSearch;
        end else if (lock_hit) begin
            state_d = StLock;
        end
    end

    always_comb begin
        h_d       = h_q;
        fill_d    = fill_q;
        run_d     = run_q;
        win_d     = win_q;
        win_err_d = win_err_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        bit_err_d = 1'b0;
        if (strobe) begin
            unique case (state_q)
                StSearch: begin
                    h_d = {h_q[PRBS_ORDER-2:0], d};
                    if (!full) begin
                        fill_d = fill_q + 1'b1;
                    end else if (good) begin
                        run_d = run_q + 1'b1;
                    end else begin
                        run_d = '0;
                    end
                    if (lock_hit) begin
                        win_d     = '0;
                        win_err_d = '0;
                    end
                end
                StLock: begin
                    // Free-running predictor: a corrupted bit is counted once, never propagated.
                    h_d   = {h_q[PRBS_ORDER-2:0], pred};
                    win_d = win_q + 1'b1;
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        win_err_d = win_err_q + 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (loss_hit) begin
                        fill_d = '0;
                        run_d  = '0;
                    end else if (win_end) begin
                        win_d     = '0;
                        win_err_d = '0;
                    end
                end
                default: ;
            endcase
        end
        if (timeout_hit) begin
            fill_d = '0;
            run_d  = '0;
        end
        if (clr_cnt) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            fill_q    <= '0;
            run_q     <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            bit_err_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            bit_err_q <= bit_err_d;
        end
    end

    always_comb begin
        locked  = (state_q == StLock);
        bit_err = bit_err_q;
        bit_cnt = bit_cnt_q;
        err_cnt = err_cnt_q;
    end

endmodule
